// File: rtl/mesh_loader_pkg.sv
// mesh_loader_pkg
// Shared types and helpers for the mesh RAM loader.
//   state_t    : loader FSM states
//   WORD_BYTES : bytes packed per RAM word
//   mask_for() : byte-enable mask for n filled lanes (0..4)
package mesh_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      WRITE,
      START,
      WAIT_HI,
      WAIT_LO
   } state_t;

   localparam int WORD_BYTES = 4;

   function automatic logic [WORD_BYTES-1:0] mask_for(input logic [2:0] n);
      logic [WORD_BYTES-1:0] m;
      case (n)
         3'd1:    m = 4'b0001;
         3'd2:    m = 4'b0011;
         3'd3:    m = 4'b0111;
         3'd4:    m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/mesh_loader_byte_packer.sv
// mesh_loader_byte_packer
// Little-endian byte-to-word packer for mesh_loader.
// Build option: MESH_LOADER_CHECKSUM_EN adds a running XOR of packed bytes.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   restart    : drop all state, store data as lane 0 (first byte of an image)
//   push       : store data in the next free lane
//   flush      : empty the lanes after the word has been written
//   data       : incoming byte
//   word       : packed word, unfilled lanes read as zero
//   count      : number of filled lanes (0..4)
//   mask       : byte-enable mask for the filled lanes
//   csum       : XOR of all bytes since restart (checksum build only)
module mesh_loader_byte_packer
   import mesh_loader_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  restart,
   input  logic                  push,
   input  logic                  flush,
   input  logic [7:0]            data,
   output logic [31:0]           word,
   output logic [2:0]            count,
   output logic [WORD_BYTES-1:0] mask
`ifdef MESH_LOADER_CHECKSUM_EN
   ,
   output logic [7:0]            csum
`endif
);

   logic [WORD_BYTES-1:0][7:0] lane_q;
   logic [2:0]                 count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_q  <= '0;
         count_q <= '0;
      end else if (restart) begin
         lane_q  <= {{((WORD_BYTES-1)*8){1'b0}}, data};
         count_q <= 3'd1;
      end else if (flush) begin
         // zeroing here keeps unfilled lanes of a partial word at 0
         lane_q  <= '0;
         count_q <= '0;
      end else if (push) begin
         lane_q[count_q[1:0]] <= data;
         count_q              <= count_q + 3'd1;
      end
   end

`ifdef MESH_LOADER_CHECKSUM_EN
   logic [7:0] acc_q;

   // the accumulator spans word boundaries, so flush leaves it alone
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc_q <= '0;
      else if (restart)
         acc_q <= data;
      else if (push)
         acc_q <= acc_q ^ data;
   end

   assign csum = acc_q;
`endif

   assign word  = lane_q;
   assign count = count_q;
   assign mask  = mask_for(count_q);

endmodule

// File: rtl/mesh_loader.sv
// mesh_loader
// Writes a little-endian byte stream into the subdivision core's input mesh
// RAM (EN/WE/A/Di port), then starts subsurf and waits for it to finish.
// Build option: MESH_LOADER_CHECKSUM_EN treats the s_last byte as an XOR
// checksum over the preceding bytes instead of data.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   s_valid/s_data/s_last      : byte stream in
//   s_ready                    : byte accepted when s_valid && s_ready
//   en/we/a/di                 : RAM write port
//   start                      : one-cycle kick to subsurf
//   sub_busy                   : subsurf busy
//   loading                    : image in progress (any state but IDLE)
//   words                      : words written by the last image
//   err                        : sticky overflow/checksum error
//
// state   | meaning
// IDLE    | ready for the first byte of an image
// COLLECT | filling lanes (or discarding after overflow)
// WRITE   | one-cycle RAM write of the packed word
// START   | start pulse to subsurf
// WAIT_HI | waiting for subsurf to raise busy
// WAIT_LO | waiting for subsurf to drop busy
module mesh_loader
   import mesh_loader_pkg::*;
#(
   parameter int ADDR_W    = 9,
   parameter int DEPTH     = 512,
   parameter int BASE_ADDR = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_valid,
   input  logic [7:0]            s_data,
   input  logic                  s_last,
   output logic                  s_ready,
   output logic                  en,
   output logic [WORD_BYTES-1:0] we,
   output logic [ADDR_W-1:0]     a,
   output logic [31:0]           di,
   output logic                  start,
   input  logic                  sub_busy,
   output logic                  loading,
   output logic [ADDR_W:0]       words,
   output logic                  err
);

   localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W:0]   WORDS_MAX = (ADDR_W+1)'(DEPTH);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [ADDR_W:0]     words_q, words_d;
   logic                err_q, err_d;
   logic                ovf_q, ovf_d;
   logic                last_q, last_d;
   logic                live_q;
   logic                accept;

   logic                  pk_restart, pk_push, pk_flush;
   logic [31:0]           pk_word;
   logic [2:0]            pk_count;
   logic [WORD_BYTES-1:0] pk_mask;
`ifdef MESH_LOADER_CHECKSUM_EN
   logic [7:0]            pk_csum;
`endif

   mesh_loader_byte_packer u_packer (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (pk_restart),
      .push    (pk_push),
      .flush   (pk_flush),
      .data    (s_data),
      .word    (pk_word),
      .count   (pk_count),
      .mask    (pk_mask)
`ifdef MESH_LOADER_CHECKSUM_EN
      ,
      .csum    (pk_csum)
`endif
   );

   // live_q keeps s_ready low while reset is held and for the first edge after
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         live_q <= 1'b0;
      else
         live_q <= 1'b1;
   end

   assign s_ready = live_q && (state_q == IDLE || state_q == COLLECT);
   assign accept  = s_valid && s_ready;
   assign a       = ptr_q;
   assign words   = words_q;
   assign err     = err_q;
   assign loading = (state_q != IDLE);

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      words_d    = words_q;
      err_d      = err_q;
      ovf_d      = ovf_q;
      last_d     = last_q;
      pk_restart = 1'b0;
      pk_push    = 1'b0;
      pk_flush   = 1'b0;
      en         = 1'b0;
      we         = '0;
      di         = '0;
      start      = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               err_d   = 1'b0;
               words_d = '0;
               ptr_d   = BASE;
               ovf_d   = 1'b0;
               last_d  = 1'b0;
`ifdef MESH_LOADER_CHECKSUM_EN
               // a lone byte is a checksum over nothing
               if (s_last) begin
                  if (s_data == 8'h00)
                     state_d = START;
                  else
                     err_d = 1'b1;
               end else begin
                  pk_restart = 1'b1;
                  state_d    = COLLECT;
               end
`else
               pk_restart = 1'b1;
               last_d     = s_last;
               state_d    = s_last ? WRITE : COLLECT;
`endif
            end
         end

         COLLECT: begin
            if (accept) begin
               if (ovf_q) begin
                  if (s_last) begin
                     ovf_d   = 1'b0;
                     state_d = IDLE;
                  end
               end
`ifdef MESH_LOADER_CHECKSUM_EN
               else if (s_last) begin
                  if (s_data != pk_csum) begin
                     err_d   = 1'b1;
                     state_d = IDLE;
                  end else if (pk_count != 3'd0) begin
                     last_d  = 1'b1;
                     state_d = WRITE;
                  end else begin
                     state_d = START;
                  end
               end
`endif
               // a byte opening a word past the end of the RAM window
               else if (pk_count == 3'd0 && words_q == WORDS_MAX) begin
                  err_d = 1'b1;
                  if (s_last)
                     state_d = IDLE;
                  else
                     ovf_d = 1'b1;
               end else begin
                  pk_push = 1'b1;
                  if (s_last) begin
                     last_d  = 1'b1;
                     state_d = WRITE;
                  end else if (pk_count == 3'd3) begin
                     state_d = WRITE;
                  end
               end
            end
         end

         WRITE: begin
            en       = 1'b1;
            we       = pk_mask;
            di       = pk_word;
            ptr_d    = ptr_q + ADDR_W'(1);
            words_d  = words_q + (ADDR_W+1)'(1);
            pk_flush = 1'b1;
            last_d   = 1'b0;
            state_d  = last_q ? START : COLLECT;
         end

         START: begin
            start   = 1'b1;
            state_d = WAIT_HI;
         end

         WAIT_HI: if (sub_busy) state_d = WAIT_LO;

         WAIT_LO: if (!sub_busy) state_d = IDLE;

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= BASE;
         words_q <= '0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         words_q <= words_d;
         err_q   <= err_d;
         ovf_q   <= ovf_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: tb/tb_mesh_loader.sv
// tb_mesh_loader
// Directed bench for mesh_loader. u_dut0 uses the default RAM depth,
// u_dut1 is built with DEPTH=2 to exercise the overflow path.
// With MESH_LOADER_CHECKSUM_EN defined the checksum scenarios run instead
// of the plain data-stream scenarios.
module tb_mesh_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic       s_valid0, s_last0, sub_busy0;
   logic [7:0] s_data0;
   logic       s_ready0, en0, start0, loading0, err0;
   logic [3:0] we0;
   logic [8:0] a0;
   logic [31:0] di0;
   logic [9:0] words0;

   logic       s_valid1, s_last1, sub_busy1;
   logic [7:0] s_data1;
   logic       s_ready1, en1, start1, loading1, err1;
   logic [3:0] we1;
   logic [8:0] a1;
   logic [31:0] di1;
   logic [9:0] words1;

   mesh_loader u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid0), .s_data(s_data0), .s_last(s_last0), .s_ready(s_ready0),
      .en(en0), .we(we0), .a(a0), .di(di0),
      .start(start0), .sub_busy(sub_busy0),
      .loading(loading0), .words(words0), .err(err0)
   );

   mesh_loader #(.DEPTH(2)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid1), .s_data(s_data1), .s_last(s_last1), .s_ready(s_ready1),
      .en(en1), .we(we1), .a(a1), .di(di1),
      .start(start1), .sub_busy(sub_busy1),
      .loading(loading1), .words(words1), .err(err1)
   );

   int vectors = 0;
   int miscompares = 0;

   // RAM write log entries are {a, di, we}
   logic [44:0] wq0[$];
   logic [44:0] wq1[$];
   int start_cnt0 = 0;
   int start_cnt1 = 0;
   int rdy_bad0 = 0;

   always @(negedge clk) begin
      if (en0) begin
         wq0.push_back({a0, di0, we0});
         if (s_ready0) rdy_bad0++;
      end
      if (en1) wq1.push_back({a1, di1, we1});
      if (start0) start_cnt0++;
      if (start1) start_cnt1++;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic idle_in();
      s_valid0 = 1'b0; s_last0 = 1'b0;
      s_valid1 = 1'b0; s_last1 = 1'b0;
   endtask

   task automatic send(input bit sel, input logic [7:0] d, input logic l);
      int n = 0;
      if (sel) begin s_valid1 = 1'b1; s_data1 = d; s_last1 = l; end
      else     begin s_valid0 = 1'b1; s_data0 = d; s_last0 = l; end
      while (((sel ? s_ready1 : s_ready0) !== 1'b1) && n < 50) begin
         tick();
         n++;
      end
      vectors++;
      if (n >= 50) begin
         miscompares++;
         $display("FAIL send_accept dut%0d byte=%h got s_ready=0 required 1", sel, d);
      end else begin
         tick();
      end
   endtask

   task automatic wait_start(input bit sel, input int exp);
      int n = 0;
      while ((sel ? start_cnt1 : start_cnt0) < exp && n < 20) begin
         tick();
         n++;
      end
      vectors++;
      if (n >= 20) begin
         miscompares++;
         $display("FAIL start_timeout dut%0d got %0d pulses required %0d", sel,
                  sel ? start_cnt1 : start_cnt0, exp);
      end
   endtask

   task automatic finish_busy();
      sub_busy0 = 1'b1;
      tick(); tick();
      sub_busy0 = 1'b0;
      tick(); tick();
   endtask

   task automatic test_reset();
      vectors += 9;
      if (s_ready0 !== 1'b0) begin miscompares++; $display("FAIL rst_s_ready got %b required 0", s_ready0); end
      if (en0 !== 1'b0)      begin miscompares++; $display("FAIL rst_en got %b required 0", en0); end
      if (we0 !== 4'h0)      begin miscompares++; $display("FAIL rst_we got %h required 0", we0); end
      if (a0 !== 9'd0)       begin miscompares++; $display("FAIL rst_a got %h required 0", a0); end
      if (di0 !== 32'h0)     begin miscompares++; $display("FAIL rst_di got %h required 0", di0); end
      if (start0 !== 1'b0)   begin miscompares++; $display("FAIL rst_start got %b required 0", start0); end
      if (loading0 !== 1'b0) begin miscompares++; $display("FAIL rst_loading got %b required 0", loading0); end
      if (words0 !== 10'd0)  begin miscompares++; $display("FAIL rst_words got %0d required 0", words0); end
      if (err0 !== 1'b0)     begin miscompares++; $display("FAIL rst_err got %b required 0", err0); end
   endtask

`ifndef MESH_LOADER_CHECKSUM_EN
   task automatic test_full_words();
      wq0.delete(); start_cnt0 = 0; rdy_bad0 = 0;
      for (int i = 1; i <= 8; i++) send(1'b0, 8'(i), i == 8);
      idle_in();
      wait_start(1'b0, 1);
      vectors += 6;
      if (wq0.size() != 2) begin
         miscompares++; $display("FAIL full_nwrites got %0d required 2", wq0.size());
      end else begin
         if (wq0[0] !== {9'd0, 32'h04030201, 4'hF}) begin miscompares++; $display("FAIL full_wr0 got %h required %h", wq0[0], {9'd0, 32'h04030201, 4'hF}); end
         if (wq0[1] !== {9'd1, 32'h08070605, 4'hF}) begin miscompares++; $display("FAIL full_wr1 got %h required %h", wq0[1], {9'd1, 32'h08070605, 4'hF}); end
      end
      if (rdy_bad0 !== 0)    begin miscompares++; $display("FAIL full_ready_in_write got %0d cycles required 0", rdy_bad0); end
      if (words0 !== 10'd2)  begin miscompares++; $display("FAIL full_words got %0d required 2", words0); end
      if (loading0 !== 1'b1) begin miscompares++; $display("FAIL full_loading got %b required 1", loading0); end
      tick(); tick(); tick();
      vectors++;
      if (start_cnt0 !== 1) begin miscompares++; $display("FAIL full_start_count got %0d required 1", start_cnt0); end
      finish_busy();
   endtask

   task automatic test_partial();
      logic [7:0] pb [6] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
      wq0.delete(); start_cnt0 = 0;
      for (int i = 0; i < 6; i++) send(1'b0, pb[i], i == 5);
      idle_in();
      wait_start(1'b0, 1);
      vectors += 2;
      if (wq0.size() != 2) begin
         miscompares++; $display("FAIL part_nwrites got %0d required 2", wq0.size());
      end else begin
         vectors++;
         if (wq0[0] !== {9'd0, 32'hDDCCBBAA, 4'hF})  begin miscompares++; $display("FAIL part_wr0 got %h required %h", wq0[0], {9'd0, 32'hDDCCBBAA, 4'hF}); end
         if (wq0[1] !== {9'd1, 32'h0000FFEE, 4'h3})  begin miscompares++; $display("FAIL part_wr1 got %h required %h", wq0[1], {9'd1, 32'h0000FFEE, 4'h3}); end
      end
      if (words0 !== 10'd2) begin miscompares++; $display("FAIL part_words got %0d required 2", words0); end
   endtask

   // runs right after test_partial, with the loader sitting in START
   task automatic test_busy_hold();
      int bad = 0;
      sub_busy0 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (s_ready0 !== 1'b0 || loading0 !== 1'b1) bad++;
      end
      sub_busy0 = 1'b0;
      vectors += 4;
      if (bad !== 0)         begin miscompares++; $display("FAIL hold_busy got %0d bad cycles required 0", bad); end
      if (s_ready0 !== 1'b0) begin miscompares++; $display("FAIL hold_ready_before got %b required 0", s_ready0); end
      tick();
      if (s_ready0 !== 1'b1) begin miscompares++; $display("FAIL hold_ready_after got %b required 1", s_ready0); end
      if (loading0 !== 1'b0) begin miscompares++; $display("FAIL hold_loading_after got %b required 0", loading0); end
   endtask

   task automatic test_overflow();
      wq1.delete(); start_cnt1 = 0;
      for (int i = 0; i < 12; i++) send(1'b1, 8'(8'h10 + i), i == 11);
      idle_in();
      tick(); tick(); tick();
      vectors += 6;
      if (wq1.size() != 2) begin
         miscompares++; $display("FAIL ovf_nwrites got %0d required 2", wq1.size());
      end else begin
         vectors++;
         if (wq1[0] !== {9'd0, 32'h13121110, 4'hF}) begin miscompares++; $display("FAIL ovf_wr0 got %h required %h", wq1[0], {9'd0, 32'h13121110, 4'hF}); end
         if (wq1[1] !== {9'd1, 32'h17161514, 4'hF}) begin miscompares++; $display("FAIL ovf_wr1 got %h required %h", wq1[1], {9'd1, 32'h17161514, 4'hF}); end
      end
      if (err1 !== 1'b1)     begin miscompares++; $display("FAIL ovf_err got %b required 1", err1); end
      if (start_cnt1 !== 0)  begin miscompares++; $display("FAIL ovf_start got %0d pulses required 0", start_cnt1); end
      if (loading1 !== 1'b0) begin miscompares++; $display("FAIL ovf_loading got %b required 0", loading1); end
      if (s_ready1 !== 1'b1) begin miscompares++; $display("FAIL ovf_ready got %b required 1", s_ready1); end
      if (words1 !== 10'd2)  begin miscompares++; $display("FAIL ovf_words got %0d required 2", words1); end
   endtask

   task automatic test_async_reset();
      wq0.delete(); start_cnt0 = 0;
      send(1'b0, 8'h31, 1'b0);
      send(1'b0, 8'h32, 1'b0);
      send(1'b0, 8'h33, 1'b0);
      idle_in();
      tick();
      vectors++;
      if (loading0 !== 1'b1) begin miscompares++; $display("FAIL arst_pre_loading got %b required 1", loading0); end
      #2;
      rst_n = 1'b0;
      #1;
      vectors += 7;
      if (loading0 !== 1'b0) begin miscompares++; $display("FAIL arst_loading got %b required 0", loading0); end
      if (s_ready0 !== 1'b0) begin miscompares++; $display("FAIL arst_s_ready got %b required 0", s_ready0); end
      if (en0 !== 1'b0)      begin miscompares++; $display("FAIL arst_en got %b required 0", en0); end
      if (di0 !== 32'h0)     begin miscompares++; $display("FAIL arst_di got %h required 0", di0); end
      if (a0 !== 9'd0)       begin miscompares++; $display("FAIL arst_a got %h required 0", a0); end
      if (err1 !== 1'b0)     begin miscompares++; $display("FAIL arst_err1 got %b required 0", err1); end
      if (wq0.size() != 0)   begin miscompares++; $display("FAIL arst_nwrites got %0d required 0", wq0.size()); end
      tick(); tick();
      rst_n = 1'b1;
      tick();
      for (int i = 1; i <= 4; i++) send(1'b0, 8'(8'h40 + i), i == 4);
      idle_in();
      wait_start(1'b0, 1);
      vectors++;
      if (wq0.size() != 1 || wq0[0] !== {9'd0, 32'h44434241, 4'hF}) begin
         miscompares++;
         $display("FAIL arst_new_image got %0d writes first %h required 1 write %h",
                  wq0.size(), (wq0.size() > 0) ? wq0[0] : 45'h0, {9'd0, 32'h44434241, 4'hF});
      end
      finish_busy();
   endtask
`else
   task automatic test_csum_ok();
      wq0.delete(); start_cnt0 = 0;
      for (int i = 1; i <= 4; i++) send(1'b0, 8'(i), 1'b0);
      send(1'b0, 8'h04, 1'b1);
      idle_in();
      wait_start(1'b0, 1);
      vectors += 3;
      if (wq0.size() != 1 || wq0[0] !== {9'd0, 32'h04030201, 4'hF}) begin
         miscompares++; $display("FAIL cs_ok_write got %0d writes required 1 write of %h", wq0.size(), {9'd0, 32'h04030201, 4'hF});
      end
      if (err0 !== 1'b0)    begin miscompares++; $display("FAIL cs_ok_err got %b required 0", err0); end
      if (words0 !== 10'd1) begin miscompares++; $display("FAIL cs_ok_words got %0d required 1", words0); end
      finish_busy();
   endtask

   task automatic test_csum_partial();
      wq0.delete(); start_cnt0 = 0;
      send(1'b0, 8'h01, 1'b0);
      send(1'b0, 8'h02, 1'b0);
      send(1'b0, 8'h03, 1'b0);
      send(1'b0, 8'h00, 1'b1);
      idle_in();
      wait_start(1'b0, 1);
      vectors++;
      if (wq0.size() != 1 || wq0[0] !== {9'd0, 32'h00030201, 4'h7}) begin
         miscompares++; $display("FAIL cs_part_write got %0d writes required 1 write of %h", wq0.size(), {9'd0, 32'h00030201, 4'h7});
      end
      finish_busy();
   endtask

   task automatic test_csum_bad();
      wq0.delete(); start_cnt0 = 0;
      for (int i = 1; i <= 4; i++) send(1'b0, 8'(i), 1'b0);
      send(1'b0, 8'h05, 1'b1);
      idle_in();
      tick(); tick(); tick(); tick();
      vectors += 5;
      if (wq0.size() != 1)   begin miscompares++; $display("FAIL cs_bad_nwrites got %0d required 1", wq0.size()); end
      if (err0 !== 1'b1)     begin miscompares++; $display("FAIL cs_bad_err got %b required 1", err0); end
      if (start_cnt0 !== 0)  begin miscompares++; $display("FAIL cs_bad_start got %0d pulses required 0", start_cnt0); end
      if (loading0 !== 1'b0) begin miscompares++; $display("FAIL cs_bad_loading got %b required 0", loading0); end
      if (s_ready0 !== 1'b1) begin miscompares++; $display("FAIL cs_bad_ready got %b required 1", s_ready0); end
   endtask

   task automatic test_csum_only();
      wq0.delete(); start_cnt0 = 0;
      send(1'b0, 8'h00, 1'b1);
      idle_in();
      wait_start(1'b0, 1);
      vectors += 3;
      if (wq0.size() != 0)  begin miscompares++; $display("FAIL cs_only_nwrites got %0d required 0", wq0.size()); end
      if (err0 !== 1'b0)    begin miscompares++; $display("FAIL cs_only_err got %b required 0", err0); end
      if (words0 !== 10'd0) begin miscompares++; $display("FAIL cs_only_words got %0d required 0", words0); end
      finish_busy();
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      s_valid0 = 1'b0; s_data0 = 8'h00; s_last0 = 1'b0; sub_busy0 = 1'b0;
      s_valid1 = 1'b0; s_data1 = 8'h00; s_last1 = 1'b0; sub_busy1 = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      test_reset();
      rst_n = 1'b1;
      tick();
`ifndef MESH_LOADER_CHECKSUM_EN
      test_full_words();
      test_partial();
      test_busy_hold();
      test_overflow();
      test_async_reset();
`else
      test_csum_ok();
      test_csum_partial();
      test_csum_bad();
      test_csum_only();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mesh_loader.md
Name: mesh_loader

Overview:
- Front-end writer for the subdivision core's input mesh RAM (DFFRAM512x32 port style: EN/WE[3:0]/A[8:0]/Di[31:0]).
- Accepts a little-endian byte stream over valid/ready, packs bytes into 32-bit words and writes them sequentially into the RAM.
- After the last byte it pulses `start` to `subsurf`, then holds off new input until `subsurf` has dropped `busy`.
- This is the writer side of the memory that `subsurf` reads.

Parameters:
- ADDR_W, 9, RAM word-address width.
- DEPTH, 512, number of writable words. Must satisfy DEPTH <= 2**ADDR_W.
- BASE_ADDR, 0, first word address written.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s_valid  input  1  byte-stream data valid.
- s_data  input  8  stream byte.
- s_last  input  1  marks the final byte of a mesh image.
- s_ready  output  1  loader can accept a byte this cycle.
- en  output  1  RAM port enable.
- we  output  4  RAM byte write enables; bit i writes di[8i+7:8i].
- a  output  ADDR_W  RAM word address.
- di  output  32  RAM write data.
- start  output  1  one-cycle start pulse to subsurf.
- sub_busy  input  1  subsurf busy.
- loading  output  1  high from first accepted byte until return to IDLE.
- words  output  ADDR_W+1  words written in the last image. Held until the next image starts.
- err  output  1  sticky error; cleared at the start of the next image.

Behaviour:
- Reset values: s_ready=0, en=0, we=0, a=BASE_ADDR, di=0, start=0, loading=0, words=0, err=0.
- Reset is asynchronous and may occur mid-operation. It returns the block to IDLE immediately; a partial word is discarded and not written.
- A byte transfer occurs when s_valid && s_ready.
- IDLE:
  - s_ready=1.
  - First accepted byte goes to lane 0, pointer=BASE_ADDR, err cleared, words cleared, loading=1. Next state is COLLECT.
  - If that byte also has s_last, go straight to WRITE.
- COLLECT:
  - s_ready=1.
  - Each byte is stored in lane = byte_index mod 4.
  - When the 4th lane fills, or s_last is accepted, go to WRITE in the next cycle.
- WRITE (exactly one cycle):
  - s_ready=0, en=1, a=pointer, di=packed word.
  - we=4'hF for a full word. For the final partial word, we has only the filled lanes set, e.g. 2 bytes gives 4'b0011. Unfilled lanes of di are 0.
  - Pointer and words increment.
  - Next state is START if the word was last, otherwise COLLECT.
  - Throughput is therefore 4 bytes per 5 cycles maximum.
- Overflow:
  - Applies when a byte would start a word at index DEPTH.
  - err is set and no further RAM writes occur. Bytes are still accepted (s_ready=1) and discarded until s_last.
  - Then go to IDLE directly: no start pulse, loading drops.
- START:
  - start=1 for one cycle, s_ready=0.
  - Next state is WAIT_HI.
- WAIT_HI: wait for sub_busy=1.
- WAIT_LO:
  - Wait for sub_busy=0, then go to IDLE with loading=0.
  - s_ready=0 throughout WAIT_HI and WAIT_LO.
- en=0 and we=0 in every state except WRITE.
- sub_busy is ignored outside WAIT_HI and WAIT_LO.
- If s_valid is low mid-word, lanes hold their values indefinitely (no timeout).

Optional Feature:
- Macro: MESH_LOADER_CHECKSUM_EN.
- When defined:
  - The byte flagged s_last is an 8-bit XOR checksum over all preceding bytes. It is not stored.
  - If the stream has buffered lanes, the partial word is written when the checksum arrives; otherwise no extra write occurs.
  - On mismatch, err=1, start is not pulsed and the block returns to IDLE.
  - A checksum-only image (single byte) writes nothing; 0x00 matches.
- When not defined: s_last marks a data byte that is stored normally, and no checksum logic exists.

Decomposition:
- Package mesh_loader_pkg holds:
  - state enum {IDLE, COLLECT, WRITE, START, WAIT_HI, WAIT_LO};
  - localparam WORD_BYTES=4;
  - lane-mask function mask_for(n) returning 4'b0001/0011/0111/1111.
- One sub-module is natural: byte_packer (lane register, lane counter, partial mask, optional XOR accumulator). The FSM, address pointer and handshakes stay in mesh_loader.

Test Plan:
- Stream 8 bytes 01..08, s_last on 08, s_valid held high:
  - writes a=0 di=0x04030201 we=F, then a=1 di=0x08070605 we=F;
  - s_ready low in each WRITE cycle;
  - start pulses once; words=2.
- Stream 6 bytes AA BB CC DD EE FF: second write a=1, di=0x0000FFEE, we=4'b0011; words=2.
- After start, hold sub_busy=1 for 20 cycles:
  - s_ready stays 0 and loading=1;
  - sub_busy->0 gives s_ready=1 next cycle and loading=0.
- DEPTH=2 build, stream 12 bytes: only a=0,1 written; err=1; no start; remaining bytes accepted.
- Assert rst_n=0 after 3 bytes: all outputs return to reset values asynchronously; no RAM write. A new 4-byte image then writes at a=0.
- MESH_LOADER_CHECKSUM_EN:
  - bytes 01 02 03 04 plus checksum 04 writes 0x04030201 and pulses start;
  - checksum 05 gives err=1 and no start.
